// File: rtl/rdcost_sched_if.sv
// rtl/rdcost_sched_if.sv - fetch and cost-accumulator bundle for rdcost_sched
interface rdcost_sched_if;
  // block fetch
  logic        rd_en;
  logic [6:0]  rd_addr;
  logic [31:0] rd_cur0, rd_cur1, rd_cur2, rd_cur3;
  logic [31:0] rd_ref0, rd_ref1, rd_ref2, rd_ref3;
  logic [20:0] rd_bits;
  // beats and controls toward the SATD / cost accumulator
  logic [31:0] cur_data0, cur_data1, cur_data2, cur_data3;
  logic [31:0] ref_data0, ref_data1, ref_data2, ref_data3;
  logic        first;
  logic        start_cost;
  logic        last;
  logic [20:0] bits;
  logic [8:0]  lamb;
  // accumulator result
  logic [20:0] rdcost;
  logic        rdcost_done;

  modport master (
    output rd_en, rd_addr,
    input  rd_cur0, rd_cur1, rd_cur2, rd_cur3,
    input  rd_ref0, rd_ref1, rd_ref2, rd_ref3, rd_bits,
    output cur_data0, cur_data1, cur_data2, cur_data3,
    output ref_data0, ref_data1, ref_data2, ref_data3,
    output first, start_cost, last, bits, lamb,
    input  rdcost, rdcost_done
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_cur0, rd_cur1, rd_cur2, rd_cur3,
    output rd_ref0, rd_ref1, rd_ref2, rd_ref3, rd_bits,
    input  cur_data0, cur_data1, cur_data2, cur_data3,
    input  ref_data0, ref_data1, ref_data2, ref_data3,
    input  first, start_cost, last, bits, lamb,
    output rdcost, rdcost_done
  );
endinterface

// File: rtl/rdcost_sched.sv
// rtl/rdcost_sched.sv - RD-cost candidate search scheduler; optional early exit under RDCOST_SCHED_EARLY_TERM_EN
module rdcost_sched #(
  parameter int HAD_LAT  = 2,
  parameter int MAX_CAND = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     cu_log2,
  input  logic [2:0]     num_cand,
  input  logic [8:0]     lamb_in,
  input  logic [20:0]    early_thr,
  rdcost_sched_if.master acc,
  output logic           busy,
  output logic           done,
  output logic [20:0]    best_cost,
  output logic [2:0]     best_idx
);
  localparam logic [3:0]  MAX_IDX  = 4'(MAX_CAND - 1);
  localparam logic [20:0] COST_MAX = 21'h1FFFFF;

  typedef enum logic [2:0] {IDLE, PRIME, ISSUE, WAIT, FIN} state_t;
  state_t state, state_nx;

  logic [2:0]  cand, ncand;
  logic [3:0]  blk, last_blk, blk_max;
  logic [8:0]  lamb_q;
  logic [20:0] bits_q;
  logic        issue, primer, start_ok, cost_ok, early_hit;
  logic        s1_v, s1_prim, s1_last;
  logic        b_v, b_first, b_last;
  logic [HAD_LAT-1:0] dl_v, dl_f, dl_l;

  // a new search may begin when idle or in the completion cycle; busy requests are dropped
  assign start_ok = start && ((state == IDLE) || (state == FIN));
  // only a result arriving while waiting for it counts
  assign cost_ok  = (state == WAIT) && acc.rdcost_done;
  // last raster block index; the reserved size code behaves as 16x16
  assign blk_max  = (cu_log2 == 2'd0) ? 4'd0 : (cu_log2 == 2'd1) ? 4'd3 : 4'd15;

`ifdef RDCOST_SCHED_EARLY_TERM_EN
  logic [20:0] thr_q;
  // early-exit threshold is captured with the other search parameters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        thr_q <= '0;
    else if (start_ok) thr_q <= early_thr;
  end
  assign early_hit = acc.rdcost < thr_q;
`else
  wire unused_early_thr = ^early_thr;
  assign early_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state plus per-cycle issue strobes
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    primer   = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nx = PRIME;
      PRIME: begin
        issue    = 1'b1;
        primer   = 1'b1;
        state_nx = ISSUE;
      end
      ISSUE: begin
        issue = 1'b1;
        if (blk == last_blk) state_nx = WAIT;
      end
      WAIT: if (cost_ok) state_nx = ((cand == ncand) || early_hit) ? FIN : PRIME;
      FIN:   state_nx = start_ok ? PRIME : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign acc.rd_en   = (state == ISSUE);
  assign acc.rd_addr = {cand, blk};
  assign busy        = (state == PRIME) || (state == ISSUE) || (state == WAIT);
  assign done        = (state == FIN);

  // search context, block walker and best-candidate tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand      <= '0;
      ncand     <= '0;
      blk       <= '0;
      last_blk  <= '0;
      lamb_q    <= '0;
      best_cost <= COST_MAX;
      best_idx  <= '0;
    end else begin
      if (start_ok) begin
        cand      <= '0;
        ncand     <= ({1'b0, num_cand} > MAX_IDX) ? MAX_IDX[2:0] : num_cand;
        last_blk  <= blk_max;
        lamb_q    <= lamb_in;
        best_cost <= COST_MAX;
        best_idx  <= '0;
      end
      if (state == PRIME)      blk <= '0;
      else if (state == ISSUE) blk <= blk + 4'd1;
      if (cost_ok) begin
        // strict compare keeps the earlier candidate on ties
        if (acc.rdcost < best_cost) begin
          best_cost <= acc.rdcost;
          best_idx  <= cand;
        end
        cand <= cand + 3'd1;
      end
    end
  end

  // tag each issue slot so the returning read data can be identified a cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_prim <= 1'b0;
      s1_last <= 1'b0;
    end else begin
      s1_v    <= issue;
      s1_prim <= primer;
      s1_last <= (state == ISSUE) && (blk == last_blk);
    end
  end

  // beat register: primer and idle slots present zero rows so the accumulator clears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_v           <= 1'b0;
      b_first       <= 1'b0;
      b_last        <= 1'b0;
      bits_q        <= '0;
      acc.cur_data0 <= '0;
      acc.cur_data1 <= '0;
      acc.cur_data2 <= '0;
      acc.cur_data3 <= '0;
      acc.ref_data0 <= '0;
      acc.ref_data1 <= '0;
      acc.ref_data2 <= '0;
      acc.ref_data3 <= '0;
    end else begin
      b_v           <= s1_v;
      b_first       <= s1_prim;
      b_last        <= s1_last;
      acc.cur_data0 <= (s1_v && !s1_prim) ? acc.rd_cur0 : '0;
      acc.cur_data1 <= (s1_v && !s1_prim) ? acc.rd_cur1 : '0;
      acc.cur_data2 <= (s1_v && !s1_prim) ? acc.rd_cur2 : '0;
      acc.cur_data3 <= (s1_v && !s1_prim) ? acc.rd_cur3 : '0;
      acc.ref_data0 <= (s1_v && !s1_prim) ? acc.rd_ref0 : '0;
      acc.ref_data1 <= (s1_v && !s1_prim) ? acc.rd_ref1 : '0;
      acc.ref_data2 <= (s1_v && !s1_prim) ? acc.rd_ref2 : '0;
      acc.ref_data3 <= (s1_v && !s1_prim) ? acc.rd_ref3 : '0;
      if (s1_last) bits_q <= acc.rd_bits;
    end
  end

  // flag delay line matching the SATD latency between a beat and its cost strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_v <= '0;
      dl_f <= '0;
      dl_l <= '0;
    end else begin
      dl_v[0] <= b_v;
      dl_f[0] <= b_first;
      dl_l[0] <= b_last;
      for (int i = 1; i < HAD_LAT; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_f[i] <= dl_f[i-1];
        dl_l[i] <= dl_l[i-1];
      end
    end
  end

  assign acc.start_cost = dl_v[HAD_LAT-1];
  assign acc.first      = dl_f[HAD_LAT-1];
  assign acc.last       = dl_l[HAD_LAT-1];
  assign acc.bits       = bits_q;
  assign acc.lamb       = lamb_q;
endmodule

// File: tb/tb_rdcost_sched.sv
// tb/tb_rdcost_sched.sv - directed self-checking bench for rdcost_sched
module tb_rdcost_sched;
  localparam int HAD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  cu_log2 = '0;
  logic [2:0]  num_cand = '0;
  logic [8:0]  lamb_in = '0;
  logic [20:0] early_thr = '0;
  logic        busy, done;
  logic [20:0] best_cost;
  logic [2:0]  best_idx;

  rdcost_sched_if ifc ();

  rdcost_sched #(.HAD_LAT(HAD_LAT), .MAX_CAND(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cu_log2(cu_log2),
    .num_cand(num_cand), .lamb_in(lamb_in), .early_thr(early_thr),
    .acc(ifc), .busy(busy), .done(done), .best_cost(best_cost), .best_idx(best_idx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // written only by the main sequence
  int          exp_n = 1;
  logic [8:0]  exp_lamb = '0;
  int          costs[8];
  int          epoch = 0;
  int          stray_req = 0;

  // written only by the monitor / accumulator model
  int          seen_epoch = 0, stray_ack = 0;
  int          exp_cand = 0, exp_blk = 0, acc_cand = 0, acc_cnt = 0, pos = 0;
  int          rd_cnt = 0, sc_cnt = 0, done_cnt = 0;
  int          rq[$];
  int          dq[$];
  logic [6:0]  daq[$];
  logic [31:0] hist[8];
  logic [6:0]  mon_a;

  // written only by the memory model
  logic        rd_pend = 1'b0;
  logic [6:0]  rd_pend_addr = '0;

  function automatic logic [31:0] cur_pat(input logic [6:0] a, input int k);
    return {4'hC, k[3:0], 17'd0, a};
  endfunction
  function automatic logic [31:0] ref_pat(input logic [6:0] a, input int k);
    return {4'hA, k[3:0], 17'd0, a};
  endfunction
  function automatic logic [20:0] bits_pat(input logic [6:0] a);
    return {14'h0A5, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // block memory: answers one cycle after rd_en, garbage otherwise
  always @(negedge clk) begin
    if (rd_pend) begin
      ifc.rd_cur0 = cur_pat(rd_pend_addr, 0); ifc.rd_cur1 = cur_pat(rd_pend_addr, 1);
      ifc.rd_cur2 = cur_pat(rd_pend_addr, 2); ifc.rd_cur3 = cur_pat(rd_pend_addr, 3);
      ifc.rd_ref0 = ref_pat(rd_pend_addr, 0); ifc.rd_ref1 = ref_pat(rd_pend_addr, 1);
      ifc.rd_ref2 = ref_pat(rd_pend_addr, 2); ifc.rd_ref3 = ref_pat(rd_pend_addr, 3);
      ifc.rd_bits = bits_pat(rd_pend_addr);
    end else begin
      ifc.rd_cur0 = 32'hDEADBEEF; ifc.rd_cur1 = 32'hDEADBEEF;
      ifc.rd_cur2 = 32'hDEADBEEF; ifc.rd_cur3 = 32'hDEADBEEF;
      ifc.rd_ref0 = 32'hDEADBEEF; ifc.rd_ref1 = 32'hDEADBEEF;
      ifc.rd_ref2 = 32'hDEADBEEF; ifc.rd_ref3 = 32'hDEADBEEF;
      ifc.rd_bits = 21'h0BAD1;
    end
    rd_pend      = ifc.rd_en;
    rd_pend_addr = ifc.rd_addr;
  end

  // monitor plus accumulator model returning costs[] three cycles after each last strobe
  always @(negedge clk) begin
    ifc.rdcost_done = 1'b0;
    if (done) done_cnt++;
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      exp_cand = 0; exp_blk = 0; acc_cand = 0; acc_cnt = 0; pos = 0;
      rd_cnt = 0; sc_cnt = 0; done_cnt = 0;
      rq.delete(); dq.delete(); daq.delete();
    end
    if (!rst_n) begin
      acc_cnt = 0; pos = 0;
      rq.delete(); dq.delete(); daq.delete();
    end else begin
      hist[cyc & 7] = ifc.cur_data0 | ifc.cur_data1 | ifc.cur_data2 | ifc.cur_data3 |
                      ifc.ref_data0 | ifc.ref_data1 | ifc.ref_data2 | ifc.ref_data3;
      if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        ifc.rdcost_done = 1'b1;
        ifc.rdcost = 21'd1;
      end
      if (acc_cnt > 0) begin
        acc_cnt--;
        if (acc_cnt == 0) begin
          ifc.rdcost_done = 1'b1;
          ifc.rdcost = 21'(costs[acc_cand]);
          acc_cand++;
        end
      end
      if (dq.size() > 0 && dq[0] == cyc) begin
        void'(dq.pop_front());
        mon_a = daq.pop_front();
        chk("cur_data0", ifc.cur_data0, cur_pat(mon_a, 0));
        chk("ref_data3", ifc.ref_data3, ref_pat(mon_a, 3));
      end
      if (ifc.rd_en) begin
        rd_cnt++;
        chk("rd_addr", 32'(ifc.rd_addr), 32'({exp_cand[2:0], exp_blk[3:0]}));
        rq.push_back(cyc);
        dq.push_back(cyc + 2);
        daq.push_back(ifc.rd_addr);
        exp_blk++;
        if (exp_blk == exp_n) begin exp_blk = 0; exp_cand++; end
      end
      if (ifc.start_cost) begin
        sc_cnt++;
        chk("first", 32'(ifc.first), 32'(pos == 0));
        chk("last", 32'(ifc.last), 32'(pos == exp_n));
        if (pos == 0) chk("primer_zero", hist[(cyc - HAD_LAT) & 7], 32'd0);
        else if (rq.size() == 0) chk("sc_orphan", 32'd1, 32'd0);
        else chk("sc_lat", 32'(cyc - rq.pop_front()), 32'(2 + HAD_LAT));
        if (ifc.last) begin
          chk("bits", 32'(ifc.bits), 32'(bits_pat({acc_cand[2:0], 4'(exp_n - 1)})));
          chk("lamb", 32'(ifc.lamb), 32'(exp_lamb));
          pos = 0;
          acc_cnt = 3;
        end else pos++;
      end
    end
  end

  task automatic launch(input logic [1:0] cu, input logic [2:0] nc, input logic [8:0] lam,
                        input logic [20:0] thr, input int nblk);
    exp_n = nblk; exp_lamb = lam; epoch++;
    @(negedge clk);
    cu_log2 = cu; num_cand = nc; lamb_in = lam; early_thr = thr; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cu_log2 = ~cu; num_cand = ~nc; lamb_in = ~lam; early_thr = ~thr;
    chk("busy_set", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin @(negedge clk); k++; end
    chk("done_seen", 32'(done), 32'd1);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_clr", 32'(busy), 32'd0);
    chk("done_cnt", 32'(done_cnt), 32'd1);
  endtask

  task automatic chk_result(input string tag, input int cost, input int idx, input int nrd);
    chk({tag, "_cost"}, 32'(best_cost), 32'(cost));
    chk({tag, "_idx"}, 32'(best_idx), 32'(idx));
    chk({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(nrd));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_best_cost", 32'(best_cost), 32'h1FFFFF);
    chk("rst_best_idx", 32'(best_idx), 32'd0);
    chk("rst_rd_en", 32'(ifc.rd_en), 32'd0);
    chk("rst_start_cost", 32'(ifc.start_cost), 32'd0);
    chk("rst_first_last", 32'({ifc.first, ifc.last}), 32'd0);
    chk("rst_bits", 32'(ifc.bits), 32'd0);
    chk("rst_lamb", 32'(ifc.lamb), 32'd0);
    chk("rst_cur_data0", ifc.cur_data0, 32'd0);
  endtask

  initial begin
    int k;
    ifc.rdcost = '0;
    ifc.rdcost_done = 1'b0;
    // reset state
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 4x4, single candidate
    costs[0] = 500;
    launch(2'd0, 3'd0, 9'h0AB, 21'd0, 1);
    wait_done(500);
    chk_result("t1", 500, 0, 1);
    chk("t1_sc_cnt", 32'(sc_cnt), 32'd2);

    // stray result while idle is ignored and the result holds
    stray_req++;
    repeat (3) @(negedge clk);
    chk("stray_cost", 32'(best_cost), 32'd500);
    chk("stray_idx", 32'(best_idx), 32'd0);

    // 8x8, three candidates, tie keeps lower index
    costs[0] = 900; costs[1] = 300; costs[2] = 300;
    launch(2'd1, 3'd2, 9'h123, 21'd0, 4);
    wait_done(500);
    chk_result("t2", 300, 1, 12);
    chk("t2_sc_cnt", 32'(sc_cnt), 32'd15);

    // 16x16 single candidate: latency, first/last placement
    costs[0] = 77;
    launch(2'd2, 3'd0, 9'h1FF, 21'd0, 16);
    wait_done(500);
    chk_result("t3", 77, 0, 16);
    chk("t3_sc_cnt", 32'(sc_cnt), 32'd17);

    // reserved size code behaves as 16x16
    costs[0] = 5; costs[1] = 4;
    launch(2'd3, 3'd1, 9'h011, 21'd0, 16);
    wait_done(500);
    chk_result("t4", 4, 1, 32);

    // start while busy is ignored
    costs[0] = 40; costs[1] = 20;
    launch(2'd0, 3'd1, 9'h055, 21'd0, 1);
    @(negedge clk);
    cu_log2 = 2'd2; num_cand = 3'd7; lamb_in = 9'h1AA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(500);
    chk_result("t5", 20, 1, 2);
    chk("t5_sc_cnt", 32'(sc_cnt), 32'd4);

    // reset while waiting on candidate 1
    costs[0] = 900; costs[1] = 300; costs[2] = 300;
    launch(2'd1, 3'd2, 9'h0F0, 21'd0, 4);
    k = 0;
    while (!(acc_cand == 1 && acc_cnt > 0) && k < 500) begin @(negedge clk); k++; end
    chk("t6_wait_reached", 32'(acc_cand == 1 && acc_cnt > 0), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);
    costs[0] = 123;
    launch(2'd0, 3'd0, 9'h0C3, 21'd0, 1);
    wait_done(500);
    chk_result("t6_fresh", 123, 0, 1);

    // early-termination threshold
    costs[0] = 900; costs[1] = 350; costs[2] = 100;
    launch(2'd1, 3'd2, 9'h077, 21'd400, 4);
    wait_done(500);
`ifdef RDCOST_SCHED_EARLY_TERM_EN
    chk_result("t7", 350, 1, 8);
`else
    chk_result("t7", 100, 2, 12);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
